// File: rtl/axi_ddr_slave_model.sv
// axi_ddr_slave_model
//   AXI4 slave backed by an on-chip array of 2^ADDR_BITS 64-bit words. Accepts
//   INCR write and read bursts of 1..256 beats, applies write strobes per byte
//   lane and echoes the transaction ID. One write and one read burst may be
//   in flight at the same time. Each direction handles one burst at a time.
//
// Ports
//   ACLK, ARESETN         clock, asynchronous active-low reset
//   S_AXI_AW*             write address channel (AWREADY out)
//   S_AXI_W*              write data channel (WREADY out)
//   S_AXI_B*              write response channel (BID/BRESP/BUSER/BVALID out)
//   S_AXI_AR*             read address channel (ARREADY out)
//   S_AXI_R*              read data channel (RID/RDATA/RRESP/RLAST/RUSER/RVALID out)
//   SIZE/BURST/LOCK/CACHE/PROT/QOS/USER inputs are accepted and ignored.
module axi_ddr_slave_model #(
    parameter int ADDR_BITS = 12
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        S_AXI_AWID,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [2:0]  S_AXI_AWSIZE,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic        S_AXI_AWLOCK,
    input  logic [3:0]  S_AXI_AWCACHE,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic [3:0]  S_AXI_AWQOS,
    input  logic        S_AXI_AWUSER,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [63:0] S_AXI_WDATA,
    input  logic [7:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WUSER,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic        S_AXI_BID,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BUSER,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic        S_AXI_ARID,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic [1:0]  S_AXI_ARLOCK,
    input  logic [3:0]  S_AXI_ARCACHE,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic [3:0]  S_AXI_ARQOS,
    input  logic        S_AXI_ARUSER,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic        S_AXI_RID,
    output logic [63:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RUSER,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] IDX_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // ---------------- write side ----------------
    w_state_t             wstate_q, wstate_d;
    logic                 awready_q, awready_d;
    logic                 wready_q, wready_d;
    logic                 bvalid_q, bvalid_d;
    logic                 awid_q, awid_d;
    logic [ADDR_BITS-1:0] wr_idx_q, wr_idx_d;
    logic [7:0]           awlen_q, awlen_d;
    logic [8:0]           wbeat_q, wbeat_d;   // 9 bits: counts past AWLEN to spot overlong bursts
    logic [1:0]           bresp_q, bresp_d;
    logic                 wr_en;

    always_comb begin
        wstate_d = wstate_q;
        awid_d   = awid_q;
        wr_idx_d = wr_idx_q;
        awlen_d  = awlen_q;
        wbeat_d  = wbeat_q;
        bresp_d  = bresp_q;
        wr_en    = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (awready_q && S_AXI_AWVALID) begin
                    awid_d   = S_AXI_AWID;
                    wr_idx_d = S_AXI_AWADDR[ADDR_BITS+2:3];
                    awlen_d  = S_AXI_AWLEN;
                    wbeat_d  = '0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wready_q && S_AXI_WVALID) begin
                    // Beats past AWLEN are swallowed without touching memory.
                    if (wbeat_q <= {1'b0, awlen_q}) begin
                        wr_en    = 1'b1;
                        wr_idx_d = wr_idx_q + IDX_ONE;
                    end
                    if (wbeat_q != 9'h1FF) begin
                        wbeat_d = wbeat_q + 9'd1;
                    end
                    if (S_AXI_WLAST) begin
                        bresp_d  = (wbeat_q == {1'b0, awlen_q}) ? 2'b00 : 2'b10;
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && S_AXI_BREADY) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
        // Handshake outputs are registered copies of the next state so that
        // they stay low while reset is applied and rise on the first edge after.
        awready_d = (wstate_d == W_IDLE);
        wready_d  = (wstate_d == W_DATA);
        bvalid_d  = (wstate_d == W_RESP);
    end

    // ---------------- read side ----------------
    r_state_t             rstate_q, rstate_d;
    logic                 arready_q, arready_d;
    logic                 rvalid_q, rvalid_d;
    logic                 rlast_q, rlast_d;
    logic                 arid_q, arid_d;
    logic [ADDR_BITS-1:0] rd_idx_q, rd_idx_d;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [7:0]           arlen_q, arlen_d;
    logic [7:0]           rbeat_q, rbeat_d;

    always_comb begin
        rstate_d = rstate_q;
        arid_d   = arid_q;
        rd_idx_d = rd_idx_q;
        arlen_d  = arlen_q;
        rbeat_d  = rbeat_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        rd_addr  = rd_idx_q;
        case (rstate_q)
            R_IDLE: begin
                if (arready_q && S_AXI_ARVALID) begin
                    arid_d   = S_AXI_ARID;
                    rd_idx_d = S_AXI_ARADDR[ADDR_BITS+2:3];
                    arlen_d  = S_AXI_ARLEN;
                    rbeat_d  = '0;
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                if (!rvalid_q) begin
                    // First cycle of the burst: the start word is being read.
                    rvalid_d = 1'b1;
                    rlast_d  = (rbeat_q == arlen_q);
                end else if (S_AXI_RREADY) begin
                    // Prefetch the following word so beats can stream every cycle;
                    // without RREADY the current word is re-read and RDATA holds.
                    rd_addr = rd_idx_q + IDX_ONE;
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        rstate_d = R_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_ONE;
                        rbeat_d  = rbeat_q + 8'd1;
                        rlast_d  = ((rbeat_q + 8'd1) == arlen_q);
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        arready_d = (rstate_d == R_IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            awid_q    <= 1'b0;
            wr_idx_q  <= '0;
            awlen_q   <= '0;
            wbeat_q   <= '0;
            bresp_q   <= 2'b00;
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arid_q    <= 1'b0;
            rd_idx_q  <= '0;
            arlen_q   <= '0;
            rbeat_q   <= '0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            awid_q    <= awid_d;
            wr_idx_q  <= wr_idx_d;
            awlen_q   <= awlen_d;
            wbeat_q   <= wbeat_d;
            bresp_q   <= bresp_d;
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            arid_q    <= arid_d;
            rd_idx_q  <= rd_idx_d;
            arlen_q   <= arlen_d;
            rbeat_q   <= rbeat_d;
        end
    end

    // ---------------- memory: one array per byte lane ----------------
    // Read and write share a clocked block per lane, so a read of a word being
    // written in the same cycle returns the previous contents. No reset here:
    // contents survive ARESETN.
    logic [63:0] rd_word;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_q;
            always_ff @(posedge ACLK) begin
                if (wr_en && S_AXI_WSTRB[gi]) begin
                    lane_mem[wr_idx_q] <= S_AXI_WDATA[gi*8 +: 8];
                end
                lane_rd_q <= lane_mem[rd_addr];
            end
            assign rd_word[gi*8 +: 8] = lane_rd_q;
        end
    endgenerate

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BID     = awid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BUSER   = 1'b0;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RID     = arid_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RUSER   = 1'b0;
    // The array output register has no reset; RDATA is forced to zero whenever
    // no beat is presented, which also covers the reset state.
    assign S_AXI_RDATA   = rvalid_q ? rd_word : 64'd0;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK,
                             S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWUSER,
                             S_AXI_WUSER, S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST,
                             S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS,
                             S_AXI_ARUSER};
endmodule

// File: tb/tb_axi_ddr_slave_model.sv
// Testbench for axi_ddr_slave_model. Expected read beats are pushed to a queue
// from a bench-side memory model when a read is issued and popped against the
// observed beats.
module tb_axi_ddr_slave_model;
    logic        clk;
    logic        ARESETN;
    logic        S_AXI_AWID;
    logic [31:0] S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [63:0] S_AXI_WDATA;
    logic [7:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic        S_AXI_BID;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BUSER;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic        S_AXI_ARID;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic        S_AXI_RID;
    logic [63:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RUSER;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    axi_ddr_slave_model #(.ADDR_BITS(12)) dut (
        .ACLK(clk), .ARESETN(ARESETN),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(3'd3), .S_AXI_AWBURST(2'b01), .S_AXI_AWLOCK(1'b0),
        .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0), .S_AXI_AWQOS(4'd0), .S_AXI_AWUSER(1'b0),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WUSER(1'b0), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BUSER(S_AXI_BUSER),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(3'd3), .S_AXI_ARBURST(2'b01), .S_AXI_ARLOCK(2'b00),
        .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0), .S_AXI_ARQOS(4'd0), .S_AXI_ARUSER(1'b0),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RUSER(S_AXI_RUSER), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] model_mem [0:4095];
    logic [63:0] wq_data[$];
    logic [7:0]  wq_strb[$];
    logic [63:0] exp_data[$];
    logic        exp_last[$];
    logic [63:0] obs_data[$];
    logic        obs_last[$];
    logic        obs_id[$];
    logic [63:0] stall_exp[$];
    logic [63:0] stall_obs[$];

    function automatic void model_write(input int idx, input logic [63:0] d, input logic [7:0] s);
        for (int b = 0; b < 8; b++) begin
            if (s[b]) model_mem[idx & 4095][b*8 +: 8] = d[b*8 +: 8];
        end
    endfunction

    function automatic logic ready_of(input int ch);
        case (ch)
            0: return S_AXI_AWREADY;
            1: return S_AXI_WREADY;
            2: return S_AXI_BVALID;
            3: return S_AXI_ARREADY;
            default: return 1'b0;
        endcase
    endfunction

    // Returns at the falling edge where the selected ready/valid is seen high.
    task automatic wait_hs(input int ch, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ready_of(ch)) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one write burst of nbeats beats from wq_data/wq_strb.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic id,
                            input int nbeats, output logic [1:0] bresp, output logic bid,
                            output bit timeout);
        bit ok;
        timeout = 1'b0;
        bresp = 2'bxx;
        bid = 1'bx;
        S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWID = id; S_AXI_AWVALID = 1'b1;
        wait_hs(0, ok);
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0;
        if (!ok) begin timeout = 1'b1; return; end
        for (int i = 0; i < nbeats; i++) begin
            S_AXI_WDATA = wq_data.pop_front();
            S_AXI_WSTRB = wq_strb.pop_front();
            S_AXI_WLAST = (i == nbeats - 1);
            S_AXI_WVALID = 1'b1;
            wait_hs(1, ok);
            @(posedge clk); #1;
            if (!ok) begin S_AXI_WVALID = 1'b0; timeout = 1'b1; return; end
        end
        S_AXI_WVALID = 1'b0;
        S_AXI_WLAST = 1'b0;
        S_AXI_BREADY = 1'b1;
        wait_hs(2, ok);
        bresp = S_AXI_BRESP;
        bid = S_AXI_BID;
        @(posedge clk); #1;
        S_AXI_BREADY = 1'b0;
        if (!ok) timeout = 1'b1;
        $display("write addr=%h len=%0d beats=%0d -> bresp=%b bid=%b", addr, len, nbeats, bresp, bid);
    endtask

    // Issues a read burst and collects the accepted beats into obs_*.
    // mode 0: RREADY always high; mode 1: throttled RREADY.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic id,
                           input int mode, output int lat, output int gaps, output bit timeout);
        bit ok;
        bit held;
        logic [63:0] held_data;
        int got;
        lat = -1; gaps = 0; got = 0; held = 1'b0; held_data = '0; timeout = 1'b0;
        obs_data.delete(); obs_last.delete(); obs_id.delete();
        stall_exp.delete(); stall_obs.delete();
        S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARID = id; S_AXI_ARVALID = 1'b1;
        wait_hs(3, ok);
        @(posedge clk); #1;
        S_AXI_ARVALID = 1'b0;
        if (!ok) begin timeout = 1'b1; return; end
        for (int cyc = 0; cyc < 3000 && got < int'(len) + 1; cyc++) begin
            if (mode == 0) S_AXI_RREADY = 1'b1;
            else S_AXI_RREADY = (cyc % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (held && S_AXI_RVALID) begin
                stall_exp.push_back(held_data);
                stall_obs.push_back(S_AXI_RDATA);
            end
            held = 1'b0;
            if (S_AXI_RVALID) begin
                if (lat < 0) lat = cyc;
                if (S_AXI_RREADY) begin
                    obs_data.push_back(S_AXI_RDATA);
                    obs_last.push_back(S_AXI_RLAST);
                    obs_id.push_back(S_AXI_RID);
                    got++;
                end else begin
                    held = 1'b1;
                    held_data = S_AXI_RDATA;
                end
            end else if (lat >= 0) begin
                gaps++;
            end
            @(posedge clk); #1;
        end
        S_AXI_RREADY = 1'b0;
        timeout = (got < int'(len) + 1);
        $display("read addr=%h len=%0d id=%b -> beats=%0d lat=%0d gaps=%0d", addr, len, id, got, lat, gaps);
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
        S_AXI_AWID = 0; S_AXI_AWADDR = 0; S_AXI_AWLEN = 0; S_AXI_WDATA = 0; S_AXI_WSTRB = 0;
        S_AXI_WLAST = 0; S_AXI_ARID = 0; S_AXI_ARADDR = 0; S_AXI_ARLEN = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_BID, S_AXI_ARREADY,
             S_AXI_RVALID, S_AXI_RLAST, S_AXI_RID, S_AXI_RRESP, S_AXI_BUSER, S_AXI_RUSER} !== 14'd0
            || S_AXI_RDATA !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs: got aw=%b w=%b b=%b ar=%b r=%b rdata=%h, want all 0",
                     S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA);
        end
        @(posedge clk); #1;
        ARESETN = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (S_AXI_AWREADY !== 1'b1 || S_AXI_ARREADY !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: got awready=%b arready=%b, want 1 1", S_AXI_AWREADY, S_AXI_ARREADY);
        end
        $display("reset: awready=%b arready=%b", S_AXI_AWREADY, S_AXI_ARREADY);
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [1:0] bresp; logic bid; bit to; int lat, gaps;
        wq_data.push_back(64'h1122334455667788); wq_strb.push_back(8'hFF);
        do_write(32'h40, 8'd0, 1'b1, 1, bresp, bid, to);
        checks++;
        if (to || bresp !== 2'b00 || bid !== 1'b1) begin
            errors++;
            $display("FAIL single_bresp: got timeout=%0d bresp=%b bid=%b, want 0 00 1", to, bresp, bid);
        end
        model_write(8, 64'h1122334455667788, 8'hFF);
        exp_data.push_back(model_mem[8]); exp_last.push_back(1'b1);
        do_read(32'h40, 8'd0, 1'b1, 0, lat, gaps, to);
        checks++;
        if (to || lat != 1) begin
            errors++;
            $display("FAIL single_latency: got timeout=%0d lat=%0d, want 0 1", to, lat);
        end
        while (exp_data.size() > 0) begin
            logic [63:0] e; logic el;
            e = exp_data.pop_front(); el = exp_last.pop_front();
            checks++;
            if (obs_data.size() == 0) begin
                errors++; $display("FAIL single_beat: missing beat, want %h", e);
            end else if (obs_data[0] !== e || obs_last[0] !== el || obs_id[0] !== 1'b1) begin
                errors++;
                $display("FAIL single_beat: got data=%h last=%b id=%b, want %h %b 1",
                         obs_data[0], obs_last[0], obs_id[0], e, el);
            end
            if (obs_data.size() > 0) begin
                void'(obs_data.pop_front()); void'(obs_last.pop_front()); void'(obs_id.pop_front());
            end
        end
        @(negedge clk);
        checks++;
        if (S_AXI_ARREADY !== 1'b1 || S_AXI_RVALID !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got arready=%b rvalid=%b, want 1 0", S_AXI_ARREADY, S_AXI_RVALID);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_burst256();
        logic [1:0] bresp; logic bid; bit to; int lat, gaps; int bad;
        for (int i = 0; i < 256; i++) begin
            wq_data.push_back(64'(i)); wq_strb.push_back(8'hFF);
        end
        do_write(32'h0, 8'd255, 1'b0, 256, bresp, bid, to);
        checks++;
        if (to || bresp !== 2'b00 || bid !== 1'b0) begin
            errors++;
            $display("FAIL b256_bresp: got timeout=%0d bresp=%b bid=%b, want 0 00 0", to, bresp, bid);
        end
        for (int i = 0; i < 256; i++) begin
            model_write(i, 64'(i), 8'hFF);
            exp_data.push_back(model_mem[i]); exp_last.push_back(i == 255);
        end
        do_read(32'h0, 8'd255, 1'b0, 0, lat, gaps, to);
        checks++;
        if (to || gaps != 0 || lat != 1 || obs_data.size() != 256) begin
            errors++;
            $display("FAIL b256_stream: got timeout=%0d gaps=%0d lat=%0d beats=%0d, want 0 0 1 256",
                     to, gaps, lat, obs_data.size());
        end
        bad = 0;
        while (exp_data.size() > 0 && obs_data.size() > 0) begin
            logic [63:0] e, o; logic el, ol;
            e = exp_data.pop_front(); el = exp_last.pop_front();
            o = obs_data.pop_front(); ol = obs_last.pop_front(); void'(obs_id.pop_front());
            checks++;
            if (o !== e || ol !== el) begin
                errors++;
                if (bad < 5) $display("FAIL b256_beat: got data=%h last=%b, want %h %b", o, ol, e, el);
                bad++;
            end
        end
        exp_data.delete(); exp_last.delete();
    endtask

    task automatic test_strobe();
        logic [1:0] bresp; logic bid; bit to; int lat, gaps;
        wq_data.push_back(64'hFFFF_FFFF_FFFF_FFFF); wq_strb.push_back(8'hFF);
        do_write(32'h100, 8'd0, 1'b0, 1, bresp, bid, to);
        wq_data.push_back(64'h0); wq_strb.push_back(8'h0F);
        do_write(32'h100, 8'd0, 1'b0, 1, bresp, bid, to);
        checks++;
        if (to || bresp !== 2'b00) begin
            errors++; $display("FAIL strobe_bresp: got timeout=%0d bresp=%b, want 0 00", to, bresp);
        end
        exp_data.push_back(64'hFFFF_FFFF_0000_0000);
        do_read(32'h100, 8'd0, 1'b0, 0, lat, gaps, to);
        checks++;
        if (to || obs_data.size() != 1 || obs_data[0] !== exp_data[0]) begin
            errors++;
            $display("FAIL strobe_data: got timeout=%0d beats=%0d data=%h, want 1 beat %h",
                     to, obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 64'hx, exp_data[0]);
        end
        model_write(32, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        model_write(32, 64'h0, 8'h0F);
        exp_data.delete();
    endtask

    task automatic test_wrap();
        logic [1:0] bresp; logic bid; bit to; int lat, gaps;
        logic [63:0] d [4];
        for (int i = 0; i < 4; i++) begin
            d[i] = {32'hA5A5_0000 | 32'(i), $urandom()};
            wq_data.push_back(d[i]); wq_strb.push_back(8'hFF);
        end
        do_write(32'h7FF0, 8'd3, 1'b1, 4, bresp, bid, to);
        checks++;
        if (to || bresp !== 2'b00 || bid !== 1'b1) begin
            errors++; $display("FAIL wrap_bresp: got timeout=%0d bresp=%b bid=%b, want 0 00 1", to, bresp, bid);
        end
        model_write(4094, d[0], 8'hFF); model_write(4095, d[1], 8'hFF);
        model_write(0, d[2], 8'hFF);    model_write(1, d[3], 8'hFF);
        // Read back the wrapped words starting from word 0 and 4094.
        for (int i = 0; i < 4; i++) exp_data.push_back(model_mem[(4094 + i) & 4095]);
        do_read(32'h7FF0, 8'd3, 1'b0, 0, lat, gaps, to);
        while (exp_data.size() > 0) begin
            logic [63:0] e;
            e = exp_data.pop_front();
            checks++;
            if (obs_data.size() == 0 || obs_data[0] !== e) begin
                errors++;
                $display("FAIL wrap_beat: got %h, want %h", (obs_data.size() > 0) ? obs_data[0] : 64'hx, e);
            end
            if (obs_data.size() > 0) void'(obs_data.pop_front());
        end
        exp_data.push_back(model_mem[0]);
        do_read(32'h8000, 8'd0, 1'b0, 0, lat, gaps, to);
        checks++;
        if (to || obs_data.size() != 1 || obs_data[0] !== exp_data[0]) begin
            errors++;
            $display("FAIL wrap_alias: got %h, want %h", (obs_data.size() > 0) ? obs_data[0] : 64'hx, exp_data[0]);
        end
        exp_data.delete();
    endtask

    task automatic test_protocol_errors();
        logic [1:0] bresp; logic bid; bit to; int lat, gaps;
        // Known background at words 0x60..0x63 and 0x80..0x83.
        for (int i = 0; i < 4; i++) begin wq_data.push_back(64'hB0B0_0000_0000_0000 | 64'(i)); wq_strb.push_back(8'hFF); end
        do_write(32'h300, 8'd3, 1'b0, 4, bresp, bid, to);
        for (int i = 0; i < 4; i++) begin wq_data.push_back(64'hC0C0_0000_0000_0000 | 64'(i)); wq_strb.push_back(8'hFF); end
        do_write(32'h400, 8'd3, 1'b0, 4, bresp, bid, to);
        for (int i = 0; i < 4; i++) begin
            model_write(96 + i, 64'hB0B0_0000_0000_0000 | 64'(i), 8'hFF);
            model_write(128 + i, 64'hC0C0_0000_0000_0000 | 64'(i), 8'hFF);
        end
        // AWLEN=3, WLAST on beat 1: short burst.
        for (int i = 0; i < 2; i++) begin wq_data.push_back(64'hD1D1_0000_0000_0000 | 64'(i)); wq_strb.push_back(8'hFF); end
        do_write(32'h300, 8'd3, 1'b1, 2, bresp, bid, to);
        checks++;
        if (to || bresp !== 2'b10 || bid !== 1'b1) begin
            errors++; $display("FAIL short_burst_bresp: got timeout=%0d bresp=%b bid=%b, want 0 10 1", to, bresp, bid);
        end
        for (int i = 0; i < 2; i++) model_write(96 + i, 64'hD1D1_0000_0000_0000 | 64'(i), 8'hFF);
        // AWLEN=1, WLAST on beat 3: beats 2-3 discarded.
        for (int i = 0; i < 4; i++) begin wq_data.push_back(64'hE2E2_0000_0000_0000 | 64'(i)); wq_strb.push_back(8'hFF); end
        do_write(32'h400, 8'd1, 1'b0, 4, bresp, bid, to);
        checks++;
        if (to || bresp !== 2'b10 || bid !== 1'b0) begin
            errors++; $display("FAIL long_burst_bresp: got timeout=%0d bresp=%b bid=%b, want 0 10 0", to, bresp, bid);
        end
        for (int i = 0; i < 2; i++) model_write(128 + i, 64'hE2E2_0000_0000_0000 | 64'(i), 8'hFF);
        for (int blk = 0; blk < 2; blk++) begin
            for (int i = 0; i < 4; i++) exp_data.push_back(model_mem[(blk == 0 ? 96 : 128) + i]);
            do_read(blk == 0 ? 32'h300 : 32'h400, 8'd3, 1'b0, 0, lat, gaps, to);
            while (exp_data.size() > 0) begin
                logic [63:0] e;
                e = exp_data.pop_front();
                checks++;
                if (obs_data.size() == 0 || obs_data[0] !== e) begin
                    errors++;
                    $display("FAIL err_burst_mem: got %h, want %h", (obs_data.size() > 0) ? obs_data[0] : 64'hx, e);
                end
                if (obs_data.size() > 0) void'(obs_data.pop_front());
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] bresp; logic bid; bit to; int lat, gaps;
        for (int i = 0; i < 8; i++) begin
            logic [63:0] v;
            v = {$urandom(), $urandom()};
            wq_data.push_back(v); wq_strb.push_back(8'hFF);
            model_write(160 + i, v, 8'hFF);
        end
        do_write(32'h500, 8'd7, 1'b0, 8, bresp, bid, to);
        for (int i = 0; i < 8; i++) begin exp_data.push_back(model_mem[160 + i]); exp_last.push_back(i == 7); end
        do_read(32'h500, 8'd7, 1'b1, 1, lat, gaps, to);
        checks++;
        if (to || obs_data.size() != 8) begin
            errors++; $display("FAIL bp_count: got timeout=%0d beats=%0d, want 0 8", to, obs_data.size());
        end
        while (exp_data.size() > 0 && obs_data.size() > 0) begin
            logic [63:0] e, o; logic el, ol, oi;
            e = exp_data.pop_front(); el = exp_last.pop_front();
            o = obs_data.pop_front(); ol = obs_last.pop_front(); oi = obs_id.pop_front();
            checks++;
            if (o !== e || ol !== el || oi !== 1'b1) begin
                errors++;
                $display("FAIL bp_beat: got data=%h last=%b id=%b, want %h %b 1", o, ol, oi, e, el);
            end
        end
        exp_data.delete(); exp_last.delete();
        while (stall_exp.size() > 0) begin
            logic [63:0] e, o;
            e = stall_exp.pop_front(); o = stall_obs.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL bp_hold: got %h after stall, want %h", o, e);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [1:0] bresp; logic bid; bit to, ok; int lat, gaps, got;
        for (int i = 0; i < 8; i++) begin
            wq_data.push_back(64'h7700_0000_0000_0000 | 64'(i * 3)); wq_strb.push_back(8'hFF);
            model_write(64 + i, 64'h7700_0000_0000_0000 | 64'(i * 3), 8'hFF);
        end
        do_write(32'h200, 8'd7, 1'b0, 8, bresp, bid, to);
        S_AXI_ARADDR = 32'h200; S_AXI_ARLEN = 8'd7; S_AXI_ARID = 1'b1; S_AXI_ARVALID = 1'b1;
        wait_hs(3, ok);
        @(posedge clk); #1;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;
        got = 0;
        obs_data.delete();
        for (int cyc = 0; cyc < 100 && got < 3; cyc++) begin
            @(negedge clk);
            if (S_AXI_RVALID) begin obs_data.push_back(S_AXI_RDATA); got++; end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (!ok || got != 3 || S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== model_mem[67]) begin
            errors++;
            $display("FAIL rst_mid_beat3: got ok=%0d beats=%0d rvalid=%b rdata=%h, want 1 3 1 %h",
                     ok, got, S_AXI_RVALID, S_AXI_RDATA, model_mem[67]);
        end
        #2 ARESETN = 1'b0;
        #1;
        checks++;
        if (S_AXI_RVALID !== 1'b0 || S_AXI_RDATA !== 64'd0 || S_AXI_ARREADY !== 1'b0 || S_AXI_RLAST !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_immediate: got rvalid=%b rdata=%h arready=%b rlast=%b, want 0 0 0 0",
                     S_AXI_RVALID, S_AXI_RDATA, S_AXI_ARREADY, S_AXI_RLAST);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_data[i] !== model_mem[64 + i]) begin
                errors++; $display("FAIL rst_mid_early_beat: beat %0d got %h, want %h", i, obs_data[i], model_mem[64 + i]);
            end
        end
        @(posedge clk); #1;
        ARESETN = 1'b1;
        S_AXI_RREADY = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (S_AXI_ARREADY !== 1'b1 || S_AXI_RVALID !== 1'b0) begin
            errors++; $display("FAIL rst_mid_release: got arready=%b rvalid=%b, want 1 0", S_AXI_ARREADY, S_AXI_RVALID);
        end
        $display("reset mid-burst: arready=%b rvalid=%b", S_AXI_ARREADY, S_AXI_RVALID);
        @(posedge clk); #1;
        // Memory contents must survive the reset.
        for (int i = 0; i < 8; i++) exp_data.push_back(model_mem[64 + i]);
        do_read(32'h200, 8'd7, 1'b0, 0, lat, gaps, to);
        while (exp_data.size() > 0) begin
            logic [63:0] e;
            e = exp_data.pop_front();
            checks++;
            if (obs_data.size() == 0 || obs_data[0] !== e) begin
                errors++;
                $display("FAIL rst_retain: got %h, want %h", (obs_data.size() > 0) ? obs_data[0] : 64'hx, e);
            end
            if (obs_data.size() > 0) void'(obs_data.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst256();
        test_strobe();
        test_wrap();
        test_protocol_errors();
        test_backpressure();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_ddr_slave_model.md
# axi_ddr_slave_model

AXI4 full-protocol slave (responder) backed by an on-chip 64-bit memory array: the far end of the DDR test master's AXI link. It accepts INCR write and read bursts of 1–256 beats, honours byte strobes and echoes IDs. It stands in for the PS DDR port in simulation and in PL-only loopback builds, so the traffic generator and checker can be exercised without the Zynq MPSoC.

## Interface
- ADDR_BITS, 12: log2 of memory depth in 64-bit words (default 4096 words = 32 KiB).
- ACLK  in  1  single clock; all ports synchronous to its rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWID in 1, S_AXI_AWADDR in 32, S_AXI_AWLEN in 8, S_AXI_AWSIZE in 3, S_AXI_AWBURST in 2, S_AXI_AWLOCK in 1, S_AXI_AWCACHE in 4, S_AXI_AWPROT in 3, S_AXI_AWQOS in 4, S_AXI_AWUSER in 1, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write address channel.
- S_AXI_WDATA in 64, S_AXI_WSTRB in 8, S_AXI_WLAST in 1, S_AXI_WUSER in 1, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write data channel.
- S_AXI_BID out 1, S_AXI_BRESP out 2, S_AXI_BUSER out 1, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response channel.
- S_AXI_ARID in 1, S_AXI_ARADDR in 32, S_AXI_ARLEN in 8, S_AXI_ARSIZE in 3, S_AXI_ARBURST in 2, S_AXI_ARLOCK in 2, S_AXI_ARCACHE in 4, S_AXI_ARPROT in 3, S_AXI_ARQOS in 4, S_AXI_ARUSER in 1, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address channel.
- S_AXI_RID out 1, S_AXI_RDATA out 64, S_AXI_RRESP out 2, S_AXI_RLAST out 1, S_AXI_RUSER out 1, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data channel.

## Operation
- Addressing: word index = ADDR[ADDR_BITS+2:3]; ADDR[2:0] and bits above ADDR_BITS+2 are ignored, so upper addresses alias. Each beat increments the index by 1, modulo 2^ADDR_BITS (wraps to 0).
- AWSIZE/ARSIZE, BURST, LOCK, CACHE, PROT, QOS and USER inputs are ignored; every burst is treated as 8-byte INCR. BUSER and RUSER are tied to 0.
- Write FSM, states W_IDLE → W_DATA → W_RESP → W_IDLE:
  - W_IDLE: AWREADY=1. On AW handshake, capture AWID, the start index and AWLEN; clear the beat counter; go to W_DATA.
  - W_DATA: WREADY=1. On each W handshake with beat count ≤ AWLEN, write the bytes with WSTRB[i]=1 into byte lane i. Beats beyond AWLEN+1 are accepted but discarded. When WLAST=1 is accepted, go to W_RESP.
  - W_RESP: BVALID=1, BID=captured AWID. BRESP=2'b00 if WLAST arrived on beat AWLEN exactly, else 2'b10 (SLVERR). On BREADY, return to W_IDLE.
- Read FSM, states R_IDLE → R_DATA → R_IDLE:
  - R_IDLE: ARREADY=1. On AR handshake, capture ARID, the start index and ARLEN, and issue the read of the first word.
  - R_DATA: RVALID=1, RID=captured ARID, RRESP=2'b00, RLAST=1 on beat ARLEN.
  - The memory read address is the next index when RVALID&&RREADY, otherwise the current index. This holds RDATA stable under backpressure and sustains back-to-back beats.
  - After the RLAST handshake, return to R_IDLE.
- Reads and writes run concurrently and independently (one write port, one read port). When a read and a write hit the same word in the same cycle, the read returns the old data.
- Memory array has no reset; contents survive ARESETN.

## Timing
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BRESP=0, BID=0, ARREADY=0, RVALID=0, RLAST=0, RID=0, RRESP=0, RDATA=0. AWREADY and ARREADY rise in the first cycle after ARESETN deasserts.
- Write: WREADY asserts the cycle after the AW handshake. BVALID asserts the cycle after the WLAST handshake. AWREADY reasserts the cycle after the B handshake. Minimum write burst cost is N+2 cycles.
- Read: AR handshake at edge k puts beat 0 valid after edge k+1. Beats follow every cycle while RREADY=1. ARREADY reasserts the cycle after the RLAST handshake.
- Only one outstanding transaction per direction; no interleaving.
- ARESETN asserted mid-burst forces all outputs to reset values immediately. The FSMs return to idle and the partial burst is abandoned; words already written remain written.

## Test plan
- Single-beat write: AWADDR=0x40, AWLEN=0, WDATA=0x1122334455667788, WSTRB=0xFF, WLAST=1 → BVALID with BRESP=0. A following read of 0x40, ARLEN=0 → RDATA=0x1122334455667788, RLAST=1, RID=ARID.
- 256-beat write of data=index to 0x0, then a 256-beat read with RREADY held high → 256 consecutive RVALID cycles, RDATA 0..255, RLAST only on beat 255.
- Strobes: write 0xFFFFFFFFFFFFFFFF, then write 0 with WSTRB=0x0F → read returns 0xFFFFFFFF00000000.
- Wrap (ADDR_BITS=12): 4-beat write at byte 0x7FF0 → words 4094, 4095, 0, 1 written. Read of 0x8000 aliases to word 0.
- Protocol errors: AWLEN=3 with WLAST on beat 1 → BRESP=2'b10. AWLEN=1 with WLAST on beat 3 → beats 2–3 discarded, BRESP=2'b10.
- Backpressure/reset: randomly toggle RREADY during an 8-beat read → RDATA stable while RVALID&&!RREADY, with no lost or duplicated beat. Pull ARESETN low at beat 3 → RVALID=0 at once, ARREADY=1 after release.
